// File: rtl/branch_resolve.sv
// Branch resolution and predictor-update stage for a 1-bit branch predictor.
// Carries fetch-time prediction metadata through decode (D) and execute (E),
// compares it with the real outcome in EX, and produces the registered
// flush/redirect and branch-table write strobes plus saturating statistics.
module branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [31:0]      if_pc4,
    input  logic             if_p,
    input  logic             if_h,
    input  logic [31:0]      if_bdest,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             wrt,
    output logic             wrp,
    output logic             Pin,
    output logic [31:0]      BdestIN,
    output logic [31:0]      PC4d,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Decode stage (p0) fields
    logic        vld_p0;
    logic [31:0] pc4_p0;
    logic        p_p0;
    logic        h_p0;
    logic [31:0] bdest_p0;

    // Execute stage (p1) fields
    logic        vld_p1;
    logic [31:0] pc4_p1;
    logic        p_p1;
    logic        h_p1;
    logic [31:0] bdest_p1;

    // Resolution terms
    logic        res;
    logic        pt;
    logic        br_res;
    logic        dir_miss;
    logic        tgt_miss;
    logic        alias_miss;
    logic        miss;
    logic        wrt_nxt;
    logic        wrp_nxt;
    logic        pin_nxt;
    logic [31:0] redirect_nxt;

    // D valid: killed by a miss and by the flush cycle even under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (miss || flush) begin
            vld_p0 <= 1'b0;
        end else if (!stall) begin
            vld_p0 <= if_valid;
        end
    end

    // D payload: captured from fetch whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (!stall) begin
            pc4_p0   <= if_pc4;
            p_p0     <= if_p;
            h_p0     <= if_h;
            bdest_p0 <= if_bdest;
        end
    end

    // ---- D -> E stage boundary ----

    // E valid: a miss kills the wrong-path instruction behind the branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (miss) begin
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= vld_p0;
        end
    end

    // E payload: follows D whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (!stall) begin
            pc4_p1   <= pc4_p0;
            p_p1     <= p_p0;
            h_p1     <= h_p0;
            bdest_p1 <= bdest_p0;
        end
    end

    // ---- E resolution (combinational) ----

    // Compare E metadata with the actual outcome; decide miss and table updates.
    always_comb begin
        res          = vld_p1 & ~stall;
        pt           = vld_p1 & h_p1 & p_p1;
        br_res       = res & ex_is_branch;
        dir_miss     = br_res & (ex_taken != pt);
        tgt_miss     = br_res & ex_taken & pt & (ex_target != bdest_p1);
        alias_miss   = res & ~ex_is_branch & pt;
        miss         = dir_miss | tgt_miss | alias_miss;
        wrt_nxt      = br_res & (~h_p1 | (ex_taken & (ex_target != bdest_p1)));
        wrp_nxt      = (br_res & (~h_p1 | (p_p1 != ex_taken))) | alias_miss;
        // An alias miss writes a not-taken prediction back.
        pin_nxt      = ex_is_branch & ex_taken;
        redirect_nxt = (ex_is_branch & ex_taken) ? ex_target : pc4_p1;
    end

    // ---- E -> output register boundary ----

    // Registered strobes pulse for one cycle; write data holds between updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrt         <= 1'b0;
            wrp         <= 1'b0;
            Pin         <= 1'b0;
            BdestIN     <= 32'd0;
            PC4d        <= 32'd0;
            flush       <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            wrt   <= wrt_nxt;
            wrp   <= wrp_nxt;
            flush <= miss;
            if (br_res || alias_miss) begin
                Pin  <= pin_nxt;
                PC4d <= pc4_p1;
            end
            if (br_res) begin
                BdestIN <= ex_target;
            end
            if (miss) begin
                redirect_pc <= redirect_nxt;
            end
        end
    end

    // Saturating statistics: resolved branches and mispredictions of any kind.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (br_res) begin
                br_count <= sat_inc(br_count);
            end
            if (miss) begin
                miss_count <= sat_inc(miss_count);
            end
        end
    end

endmodule
